// File: rtl/alu_share_arb.sv
// Round-robin arbiter that shares one 32-bit ALU between two valid/ready requesters,
// with a one-entry registered response buffer per requester. Optional macro: ALU_SHARE_PERF_EN.
module alu_share_arb #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero
`ifdef ALU_SHARE_PERF_EN
    ,
    output logic [CNT_W-1:0]  conflict_cnt
`endif
);

    if (DATA_W != 32 || OP_W != 3 || CNT_W < 1) begin : g_param_check
        $error("alu_share_arb supports only DATA_W=32, OP_W=3, CNT_W>=1");
    end

    logic              r_rr_ptr;
    logic [1:0]        r_rsp_valid;
    logic [DATA_W-1:0] r_rsp0_result;
    logic [DATA_W-1:0] r_rsp1_result;
    logic [1:0]        r_rsp_zero;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_grant0;
    logic              w_grant1;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [OP_W-1:0]   w_op;
    logic [DATA_W-1:0] w_alu;
    logic              w_alu_zero;

    // A full buffer that is being drained this cycle can accept a new result.
    assign w_elig0  = req0_valid && (!r_rsp_valid[0] || rsp0_ready);
    assign w_elig1  = req1_valid && (!r_rsp_valid[1] || rsp1_ready);
    assign w_grant0 = !reset && w_elig0 && (!w_elig1 || !r_rr_ptr);
    assign w_grant1 = !reset && w_elig1 && (!w_elig0 ||  r_rr_ptr);

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    assign w_a  = w_grant1 ? req1_a  : req0_a;
    assign w_b  = w_grant1 ? req1_b  : req0_b;
    assign w_op = w_grant1 ? req1_op : req0_op;

    always_comb begin
        w_alu = '0;
        case (w_op)
            3'b000:  w_alu = w_a + w_b;
            3'b001:  w_alu = w_a - w_b;
            3'b010:  w_alu = w_a & w_b;
            3'b011:  w_alu = w_a | w_b;
            3'b101:  w_alu = {{(DATA_W-1){1'b0}}, (w_a < w_b)};
            // Shift amounts of 32 or more push every bit out.
            3'b110:  w_alu = (|w_b[DATA_W-1:5]) ? '0 : (w_a << w_b[4:0]);
            default: w_alu = '0;
        endcase
    end

    assign w_alu_zero = (w_alu == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr      <= 1'b0;
            r_rsp_valid   <= 2'b00;
            r_rsp0_result <= '0;
            r_rsp1_result <= '0;
            r_rsp_zero    <= 2'b00;
        end else begin
            if (w_grant0) begin
                r_rsp_valid[0] <= 1'b1;
                r_rsp0_result  <= w_alu;
                r_rsp_zero[0]  <= w_alu_zero;
            end else if (r_rsp_valid[0] && rsp0_ready) begin
                r_rsp_valid[0] <= 1'b0;
            end

            if (w_grant1) begin
                r_rsp_valid[1] <= 1'b1;
                r_rsp1_result  <= w_alu;
                r_rsp_zero[1]  <= w_alu_zero;
            end else if (r_rsp_valid[1] && rsp1_ready) begin
                r_rsp_valid[1] <= 1'b0;
            end

            if (w_grant0) begin
                r_rr_ptr <= 1'b1;
            end else if (w_grant1) begin
                r_rr_ptr <= 1'b0;
            end
        end
    end

    assign rsp0_valid  = r_rsp_valid[0];
    assign rsp0_result = r_rsp0_result;
    assign rsp0_zero   = r_rsp_zero[0];
    assign rsp1_valid  = r_rsp_valid[1];
    assign rsp1_result = r_rsp1_result;
    assign rsp1_zero   = r_rsp_zero[1];

`ifdef ALU_SHARE_PERF_EN
    logic [CNT_W-1:0] r_conflict_cnt;

    // Counts cycles where one eligible port had to lose arbitration; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict_cnt <= '0;
        end else if (w_elig0 && w_elig1 && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + 1'b1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
